// File: rtl/vga_pkg.sv
// Shared raster definitions for the parametrised VGA timing generator:
// region encoding, standard mode constant sets and the axis total helper.
package vga_pkg;

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} region_t;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_front;
        int unsigned h_sync;
        int unsigned h_back;
        int unsigned v_active;
        int unsigned v_front;
        int unsigned v_sync;
        int unsigned v_back;
    } mode_t;

    localparam mode_t MODE_640x480_60 = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam mode_t MODE_800x600_60 = '{800, 40, 128, 88, 600, 1, 4, 23};

    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: a wrapping position counter plus its region state,
// both advancing together on adv so region always describes cnt.
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = 800,
    parameter int unsigned FRONT  = 40,
    parameter int unsigned SYNC   = 128,
    parameter int unsigned BACK   = 88,
    parameter int          CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [CNT_W-1:0] cnt,
    output region_t          region,
    output logic             wrap
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

    if ((SYNC == 0) || (ACTIVE == 0) ||
        ((longint'(TOTAL) - 1) >= (longint'(1) << CNT_W))) begin : g_bad_mode
        $error("vga_axis_cnt: zero ACTIVE/SYNC or CNT_W too small for the axis total");
    end

    // Boundaries are one bit wider so a total of exactly 2**CNT_W does not alias to 0.
    localparam logic [CNT_W:0]   B_FRONT = (CNT_W+1)'(ACTIVE);
    localparam logic [CNT_W:0]   B_SYNC  = (CNT_W+1)'(ACTIVE + FRONT);
    localparam logic [CNT_W:0]   B_BACK  = (CNT_W+1)'(ACTIVE + FRONT + SYNC);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_next;

    function automatic region_t region_of(input logic [CNT_W-1:0] c);
        if ({1'b0, c} < B_FRONT) return vga_pkg::ACTIVE;
        if ({1'b0, c} < B_SYNC)  return vga_pkg::FRONT;
        if ({1'b0, c} < B_BACK)  return vga_pkg::SYNC;
        return vga_pkg::BACK;
    endfunction

    assign wrap     = (cnt == LAST);
    assign cnt_next = wrap ? '0 : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            region <= vga_pkg::ACTIVE;
        end else if (adv) begin
            cnt    <= cnt_next;
            region <= region_of(cnt_next);
        end
    end

endmodule

// File: rtl/vga_timing.sv
// Parametrised raster timing generator: H/V axis counters with registered
// sync, data-enable, active-area coordinates and line/frame start strobes.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FRONT  = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BACK   = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FRONT  = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BACK   = 23,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int          CNT_W    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] xpos,
    output logic [CNT_W-1:0] ypos,
    output logic             line_start,
    output logic             frame_start
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    region_t          h_region;
    region_t          v_region;
    logic             h_wrap;
    logic             v_wrap_unused;
    logic             active_now;

    vga_axis_cnt #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk(clk), .rst_n(rst_n), .adv(ce),
        .cnt(h_cnt), .region(h_region), .wrap(h_wrap)
    );

    vga_axis_cnt #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk(clk), .rst_n(rst_n), .adv(h_wrap & ce),
        .cnt(v_cnt), .region(v_region), .wrap(v_wrap_unused)
    );

    assign active_now = (h_region == ACTIVE) && (v_region == ACTIVE);

    // Outputs describe the counter position of the previous ce-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            xpos        <= '0;
            ypos        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            hsync       <= (h_region == SYNC) ? HS_POL : ~HS_POL;
            vsync       <= (v_region == SYNC) ? VS_POL : ~VS_POL;
            de          <= active_now;
            xpos        <= active_now ? h_cnt : '0;
            ypos        <= active_now ? v_cnt : '0;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: small-mode raster against a position model with a
// scoreboard, segment totals from a table, async reset and default-mode line checks.
`timescale 1ns/1ps
module tb_vga_timing;

    localparam int W = 4;

    typedef struct packed {
        logic         hsync;
        logic         vsync;
        logic         de;
        logic [W-1:0] xpos;
        logic [W-1:0] ypos;
        logic         line_start;
        logic         frame_start;
    } outs_t;

    typedef struct {
        int ce_div;   // 0 = random ce
        int cycles;
        int exp_de;   // -1 = totals not checked
        int exp_fs;
        int exp_ls;
        int exp_hs;
        int exp_vs;
    } seg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;

    logic         hsync, vsync, de, line_start, frame_start;
    logic [W-1:0] xpos, ypos;

    logic         b_hsync, b_vsync, b_de, b_line_start, b_frame_start;
    logic [10:0]  b_xpos, b_ypos;

    vga_timing #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .CNT_W(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .hsync(hsync), .vsync(vsync), .de(de),
        .xpos(xpos), .ypos(ypos),
        .line_start(line_start), .frame_start(frame_start)
    );

    vga_timing dut_big (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
        .xpos(b_xpos), .ypos(b_ypos),
        .line_start(b_line_start), .frame_start(b_frame_start)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    int    mh = 0;
    int    mv = 0;
    outs_t held;
    outs_t sb[$];
    int    seg_de, seg_fs, seg_ls, seg_hs, seg_vs;

    function automatic outs_t reset_out();
        outs_t o;
        o = '0;
        o.hsync = 1'b1;
        o.vsync = 1'b0;
        return o;
    endfunction

    // Small mode: H 8/2/3/2, V 4/1/2/1, hsync active-low, vsync active-high.
    function automatic outs_t expect_at(input int h, input int v);
        outs_t o;
        o.de          = (h < 8) && (v < 4);
        o.hsync       = !((h >= 10) && (h <= 12));
        o.vsync       = (v == 5) || (v == 6);
        o.xpos        = o.de ? W'(h) : '0;
        o.ypos        = o.de ? W'(v) : '0;
        o.line_start  = (h == 0);
        o.frame_start = (h == 0) && (v == 0);
        return o;
    endfunction

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_outs(input string name, input outs_t exp);
        outs_t got;
        got = {hsync, vsync, de, xpos, ypos, line_start, frame_start};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at model (%0d,%0d): got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b expected hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                     name, mh, mv, got.hsync, got.vsync, got.de, got.xpos, got.ypos,
                     got.line_start, got.frame_start, exp.hsync, exp.vsync, exp.de,
                     exp.xpos, exp.ypos, exp.line_start, exp.frame_start);
        end
    endtask

    task automatic step(input logic ce_val);
        ce = ce_val;
        if (ce_val) begin
            sb.push_back(expect_at(mh, mv));
            mh++;
            if (mh == 15) begin
                mh = 0;
                mv = (mv + 1) % 8;
            end
        end
        @(posedge clk);
        #1;
        if (ce_val) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_empty");
            end else begin
                held = sb.pop_front();
            end
        end
        check_outs("raster", held);
        seg_de += int'(de);
        seg_fs += int'(frame_start);
        seg_ls += int'(line_start);
        seg_hs += int'(!hsync);
        seg_vs += int'(vsync);
    endtask

    initial begin
        seg_t segs[4];
        int   guard;
        int   ls_first, ls_second, b_de_line, b_hs_line, b_vs_cnt, b_xmax;

        segs[0] = '{1, 15, 8, 1, 1, 3, 0};
        segs[1] = '{1, 225, 56, 1, 15, 45, 60};
        segs[2] = '{4, 480, 128, 4, 32, 96, 120};
        segs[3] = '{0, 100, -1, -1, -1, -1, -1};

        rst_n = 1'b0;
        ce    = 1'b0;
        held  = reset_out();
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset_values", reset_out());
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 4; s++) begin
            seg_de = 0; seg_fs = 0; seg_ls = 0; seg_hs = 0; seg_vs = 0;
            for (int c = 0; c < segs[s].cycles; c++) begin
                logic cv;
                if (segs[s].ce_div == 0) cv = 1'($urandom_range(0, 1));
                else                     cv = ((c % segs[s].ce_div) == 0);
                step(cv);
            end
            if (segs[s].exp_de >= 0) begin
                check_int($sformatf("seg%0d_de_count", s), seg_de, segs[s].exp_de);
                check_int($sformatf("seg%0d_frame_start_count", s), seg_fs, segs[s].exp_fs);
                check_int($sformatf("seg%0d_line_start_count", s), seg_ls, segs[s].exp_ls);
                check_int($sformatf("seg%0d_hsync_active", s), seg_hs, segs[s].exp_hs);
                check_int($sformatf("seg%0d_vsync_active", s), seg_vs, segs[s].exp_vs);
            end
        end

        // Walk the counter to (10,5), then pull reset between clock edges.
        guard = 0;
        while (!((mh == 10) && (mv == 5)) && (guard < 200)) begin
            step(1'b1);
            guard++;
        end
        check_int("reach_10_5_in_budget", int'(guard < 200), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outs("async_reset_mid_clock", reset_out());
        sb.delete();
        mh = 0;
        mv = 0;
        held = reset_out();
        @(posedge clk);
        #1;
        check_outs("reset_held", reset_out());
        @(negedge clk);
        rst_n = 1'b1;

        ls_first = -1; ls_second = -1;
        b_de_line = 0; b_hs_line = 0; b_vs_cnt = 0; b_xmax = 0;
        for (int i = 0; i < 2200; i++) begin
            step(1'b1);
            if (i == 0) begin
                check_int("restart_frame_start", int'(frame_start), 1);
                check_int("big_first_frame_start", int'(b_frame_start), 1);
            end
            if (b_line_start) begin
                if (ls_first < 0)       ls_first = i;
                else if (ls_second < 0) ls_second = i;
            end
            if ((ls_first >= 0) && (ls_second < 0)) begin
                b_de_line += int'(b_de);
                b_hs_line += int'(b_hsync);
                if (b_de && (int'(b_xpos) > b_xmax)) b_xmax = int'(b_xpos);
            end
            b_vs_cnt += int'(b_vsync);
            if (i == 1061) begin
                check_int("big_xpos_line1", int'(b_xpos), 5);
                check_int("big_ypos_line1", int'(b_ypos), 1);
            end
        end
        check_int("big_first_line_start", ls_first, 0);
        check_int("big_h_period", ls_second - ls_first, 1056);
        check_int("big_de_per_line", b_de_line, 800);
        check_int("big_hsync_width", b_hs_line, 128);
        check_int("big_xpos_max", b_xmax, 799);
        check_int("big_no_vsync_early", b_vs_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
